// File: rtl/enemy_hit_scheduler_pkg.sv
// Shared game definitions: coordinate/health widths, enemy hitbox window
// offsets, the scan FSM state encoding and the health-load helper.
package enemy_hit_scheduler_pkg;

  localparam int COORD_W  = 10;
  localparam int HEALTH_W = 3;
  // Signed width for window arithmetic: covers -40 .. 1023+50 without wrap.
  localparam int CALC_W   = 12;

  // Hitbox window relative to the enemy origin.
  localparam int HB_X_LO = -10;
  localparam int HB_X_HI = 50;
  localparam int HB_Y_LO = -40;
  localparam int HB_Y_HI = 50;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } scan_state_t;

  // Health loaded at reset/respawn; a zero setting would spawn a dead enemy,
  // so it is promoted to one.
  function automatic logic [HEALTH_W-1:0] eff_health(input logic [HEALTH_W-1:0] h);
    return (h == '0) ? HEALTH_W'(1) : h;
  endfunction

endpackage

// File: rtl/enemy_hit_scheduler_hitbox.sv
// Combinational hitbox window test: is the bullet (bx,by) inside the window
// anchored at the target (ex,ey)? Shared with the player-hit logic.
module hitbox_compare
  import enemy_hit_scheduler_pkg::*;
(
  input  logic [COORD_W-1:0] ex,
  input  logic [COORD_W-1:0] ey,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               hit
);

  localparam logic signed [CALC_W-1:0] X_LO = CALC_W'(HB_X_LO);
  localparam logic signed [CALC_W-1:0] X_HI = CALC_W'(HB_X_HI);
  localparam logic signed [CALC_W-1:0] Y_LO = CALC_W'(HB_Y_LO);
  localparam logic signed [CALC_W-1:0] Y_HI = CALC_W'(HB_Y_HI);

  logic signed [CALC_W-1:0] sex, sey, sbx, sby;
  logic signed [CALC_W-1:0] x_lo, x_hi, y_lo, y_hi;

  // Widen to signed so edges below zero or above 1023 compare correctly.
  always_comb begin
    sex  = $signed({{(CALC_W-COORD_W){1'b0}}, ex});
    sey  = $signed({{(CALC_W-COORD_W){1'b0}}, ey});
    sbx  = $signed({{(CALC_W-COORD_W){1'b0}}, bx});
    sby  = $signed({{(CALC_W-COORD_W){1'b0}}, by});
    x_lo = sex + X_LO;
    x_hi = sex + X_HI;
    y_lo = sey + Y_LO;
    y_hi = sey + Y_HI;
    hit  = (sbx >= x_lo) && (sbx < x_hi) && (sby > y_lo) && (sby < y_hi);
  end

endmodule

// File: rtl/enemy_hit_scheduler.sv
// Per-frame enemy/bullet collision scheduler. Each frame_tick snapshots the
// playfield and walks every enemy/bullet pair one per cycle, decrementing
// enemy health, consuming bullets and running per-enemy explosion timers.
module enemy_hit_scheduler
  import enemy_hit_scheduler_pkg::*;
#(
  parameter int N_EN        = 4,
  parameter int N_B         = 4,
  parameter int BOOM_FRAMES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic [COORD_W*N_EN-1:0] ep_x,
  input  logic [COORD_W*N_EN-1:0] ep_y,
  input  logic [N_EN-1:0]         enemy_en,
  input  logic [COORD_W*N_B-1:0]  b_x,
  input  logic [COORD_W*N_B-1:0]  b_y,
  input  logic [N_B-1:0]          bullet_en,
  input  logic [HEALTH_W-1:0]     health_init,
  output logic [N_B-1:0]          bullet_kill,
  output logic                    scan_done,
  output logic [N_EN-1:0]         enemy_boom,
  output logic [N_EN-1:0]         enemy_alive,
  output logic                    busy,
  output logic                    overrun
);

  localparam int PAIRS = N_EN * N_B;
  localparam int P_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int E_W   = (N_EN > 1) ? $clog2(N_EN) : 1;
  localparam int B_W   = (N_B > 1) ? $clog2(N_B) : 1;
  localparam int CNT_W = $clog2(BOOM_FRAMES + 1);

  scan_state_t state, state_nx;

  logic [P_W-1:0] p;
  logic [E_W-1:0] e_idx;
  logic [B_W-1:0] b_idx;
  logic [N_B-1:0] consumed;

  logic [N_EN-1:0][COORD_W-1:0] snap_ex, snap_ey;
  logic [N_B-1:0][COORD_W-1:0]  snap_bx, snap_by;
  logic [N_EN-1:0]              snap_een;
  logic [N_B-1:0]               snap_ben;

  logic [N_EN-1:0][HEALTH_W-1:0] health;
  logic [N_EN-1:0][CNT_W-1:0]    boom_cnt;

  logic [COORD_W-1:0] cur_ex, cur_ey, cur_bx, cur_by;
  logic               win_hit;
  logic               pair_hit;
  logic               last_pair;
  logic               start;

  assign start     = (state == IDLE) && frame_tick;
  assign last_pair = (p == P_W'(PAIRS - 1));
  assign busy      = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state and report outputs; the kill mask is only driven in REPORT.
  always_comb begin
    state_nx    = state;
    scan_done   = 1'b0;
    bullet_kill = '0;
    unique case (state)
      IDLE: begin
        if (frame_tick) state_nx = SCAN;
      end
      SCAN: begin
        if (last_pair) state_nx = REPORT;
      end
      REPORT: begin
        state_nx    = IDLE;
        scan_done   = 1'b1;
        bullet_kill = consumed;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pair walk: p counts linearly while e_idx/b_idx track p / N_B and p mod N_B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p        <= '0;
      e_idx    <= '0;
      b_idx    <= '0;
      consumed <= '0;
      overrun  <= 1'b0;
    end else begin
      if (frame_tick && (state != IDLE)) overrun <= 1'b1;
      if (start) begin
        p        <= '0;
        e_idx    <= '0;
        b_idx    <= '0;
        consumed <= '0;
      end else if (state == SCAN) begin
        if (pair_hit) consumed[b_idx] <= 1'b1;
        if (last_pair) begin
          p     <= '0;
          e_idx <= '0;
          b_idx <= '0;
        end else begin
          p <= p + 1'b1;
          if (b_idx == B_W'(N_B - 1)) begin
            b_idx <= '0;
            e_idx <= e_idx + 1'b1;
          end else begin
            b_idx <= b_idx + 1'b1;
          end
        end
      end
    end
  end

  // Playfield snapshot taken on the scan start edge; pure data, no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      snap_ex  <= ep_x;
      snap_ey  <= ep_y;
      snap_een <= enemy_en;
      snap_bx  <= b_x;
      snap_by  <= b_y;
      snap_ben <= bullet_en;
    end
  end

  // Select the current pair and qualify the window hit with slot status.
  always_comb begin
    cur_ex   = snap_ex[e_idx];
    cur_ey   = snap_ey[e_idx];
    cur_bx   = snap_bx[b_idx];
    cur_by   = snap_by[b_idx];
    pair_hit = (state == SCAN) && snap_een[e_idx] && snap_ben[b_idx] &&
               (health[e_idx] != '0) && !consumed[b_idx] &&
               !enemy_boom[e_idx] && win_hit;
  end

  hitbox_compare u_hitbox (
    .ex  (cur_ex),
    .ey  (cur_ey),
    .bx  (cur_bx),
    .by  (cur_by),
    .hit (win_hit)
  );

  // Enemy health and explosion timers; frame ticks age explosions in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_EN; i++) begin
        health[i]   <= eff_health(health_init);
        boom_cnt[i] <= '0;
      end
      enemy_boom <= '0;
    end else begin
      for (int i = 0; i < N_EN; i++) begin
        if (frame_tick && (boom_cnt[i] != '0)) begin
          boom_cnt[i] <= boom_cnt[i] - 1'b1;
          if (boom_cnt[i] == CNT_W'(1)) begin
            enemy_boom[i] <= 1'b0;
            health[i]     <= eff_health(health_init);
          end
        end
        if (pair_hit && (e_idx == E_W'(i))) begin
          health[i] <= health[i] - 1'b1;
          if (health[i] == HEALTH_W'(1)) begin
            enemy_boom[i] <= 1'b1;
            boom_cnt[i]   <= CNT_W'(BOOM_FRAMES);
          end
        end
      end
    end
  end

  // Alive flags follow health directly.
  always_comb begin
    enemy_alive = '0;
    for (int i = 0; i < N_EN; i++) begin
      enemy_alive[i] = (health[i] != '0);
    end
  end

endmodule

// File: tb/tb_enemy_hit_scheduler.sv
// Testbench for enemy_hit_scheduler: directed scenarios plus randomized frames
// checked against a frame-level behavioural model.
module tb_enemy_hit_scheduler;

  localparam int N_EN = 4;
  localparam int N_B  = 4;
  localparam int BOOM = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_tick;
  logic [10*N_EN-1:0] ep_x, ep_y;
  logic [N_EN-1:0] enemy_en;
  logic [10*N_B-1:0]  b_x, b_y;
  logic [N_B-1:0]  bullet_en;
  logic [2:0]      health_init;
  logic [N_B-1:0]  bullet_kill;
  logic            scan_done;
  logic [N_EN-1:0] enemy_boom;
  logic [N_EN-1:0] enemy_alive;
  logic            busy;
  logic            overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: playfield and per-enemy health/explosion counters.
  int m_ex[N_EN], m_ey[N_EN], m_bx[N_B], m_by[N_B];
  bit m_een[N_EN], m_ben[N_B];
  int m_health[N_EN], m_cnt[N_EN];
  int m_init;

  enemy_hit_scheduler #(.N_EN(N_EN), .N_B(N_B), .BOOM_FRAMES(BOOM)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .ep_x        (ep_x),
    .ep_y        (ep_y),
    .enemy_en    (enemy_en),
    .b_x         (b_x),
    .b_y         (b_y),
    .bullet_en   (bullet_en),
    .health_init (health_init),
    .bullet_kill (bullet_kill),
    .scan_done   (scan_done),
    .enemy_boom  (enemy_boom),
    .enemy_alive (enemy_alive),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic apply_inputs();
    for (int i = 0; i < N_EN; i++) begin
      ep_x[i*10 +: 10] = 10'(m_ex[i]);
      ep_y[i*10 +: 10] = 10'(m_ey[i]);
      enemy_en[i]      = m_een[i];
    end
    for (int j = 0; j < N_B; j++) begin
      b_x[j*10 +: 10] = 10'(m_bx[j]);
      b_y[j*10 +: 10] = 10'(m_by[j]);
      bullet_en[j]    = m_ben[j];
    end
  endtask

  task automatic clear_field();
    for (int i = 0; i < N_EN; i++) begin m_ex[i] = 0; m_ey[i] = 0; m_een[i] = 0; end
    for (int j = 0; j < N_B; j++) begin m_bx[j] = 0; m_by[j] = 0; m_ben[j] = 0; end
    apply_inputs();
  endtask

  task automatic do_reset(input int init);
    @(negedge clk);
    health_init = 3'(init);
    m_init      = (init == 0) ? 1 : init;
    rst         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N_EN; i++) begin m_health[i] = m_init; m_cnt[i] = 0; end
  endtask

  function automatic bit in_box(input int ex, input int ey, input int bx, input int by);
    return (bx >= ex - 10) && (bx < ex + 50) && (by > ey - 40) && (by < ey + 50);
  endfunction

  // One frame of game rules: age explosions (respawn at expiry), then resolve
  // hits enemy-major so each bullet goes to the lowest-index eligible enemy.
  task automatic model_frame(output logic [N_B-1:0] kill);
    kill = '0;
    for (int i = 0; i < N_EN; i++) begin
      if (m_cnt[i] != 0) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) m_health[i] = m_init;
      end
    end
    for (int e = 0; e < N_EN; e++) begin
      for (int b = 0; b < N_B; b++) begin
        if (m_een[e] && m_ben[b] && m_health[e] > 0 && !kill[b] && m_cnt[e] == 0 &&
            in_box(m_ex[e], m_ey[e], m_bx[b], m_by[b])) begin
          kill[b] = 1'b1;
          m_health[e]--;
          if (m_health[e] == 0) m_cnt[e] = BOOM;
        end
      end
    end
  endtask

  // Issue one tick and observe for 40 cycles (always ends idle).
  task automatic run_scan(output int lat, output logic [N_B-1:0] kill, output int n_done,
                          output bit busy_seen, output bit kill_outside);
    @(negedge clk);
    frame_tick   = 1'b1;
    lat          = -1;
    kill         = '0;
    n_done       = 0;
    busy_seen    = 1'b0;
    kill_outside = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin frame_tick = 1'b0; busy_seen = busy; end
      if (scan_done) begin
        n_done++;
        if (lat < 0) begin lat = i; kill = bullet_kill; end
      end else if (bullet_kill != '0) begin
        kill_outside = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    clear_field();
    frame_tick = 1'b0;
    do_reset(0);
    for (int i = 0; i < N_EN; i++) begin
      n_checks++;
      if (dut.health[i] !== 3'd1) begin n_fail++; $display("FAIL reset_health0map[%0d]: got %0d want 1", i, dut.health[i]); end
    end
    do_reset(3);
    n_checks++;
    if ({busy, scan_done, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: busy/done/ovr got %b want 000", {busy, scan_done, overrun}); end
    n_checks++;
    if (bullet_kill !== 4'b0000 || enemy_boom !== 4'b0000) begin n_fail++; $display("FAIL reset_masks: kill %b boom %b want 0", bullet_kill, enemy_boom); end
    n_checks++;
    if (enemy_alive !== 4'b1111) begin n_fail++; $display("FAIL reset_alive: got %b want 1111", enemy_alive); end
    for (int i = 0; i < N_EN; i++) begin
      n_checks++;
      if (dut.health[i] !== 3'd3) begin n_fail++; $display("FAIL reset_health[%0d]: got %0d want 3", i, dut.health[i]); end
    end
  endtask

  task automatic test_single_hit();
    int lat, nd; logic [N_B-1:0] kill; bit bs, ko;
    do_reset(3);
    clear_field();
    m_ex[0] = 100; m_ey[0] = 200; m_een[0] = 1;
    m_bx[0] = 120; m_by[0] = 210; m_ben[0] = 1;
    apply_inputs();
    run_scan(lat, kill, nd, bs, ko);
    n_checks++;
    if (lat !== 17) begin n_fail++; $display("FAIL single_latency: got %0d want 17", lat); end
    n_checks++;
    if (kill !== 4'b0001) begin n_fail++; $display("FAIL single_kill: got %b want 0001", kill); end
    n_checks++;
    if (bs !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bs); end
    n_checks++;
    if (dut.health[0] !== 3'd2 || enemy_alive[0] !== 1'b1) begin n_fail++; $display("FAIL single_health: got %0d alive %b want 2/1", dut.health[0], enemy_alive[0]); end
    n_checks++;
    if (nd !== 1 || ko !== 1'b0) begin n_fail++; $display("FAIL single_done: done %0d stray_kill %b want 1/0", nd, ko); end
  endtask

  task automatic test_kill_respawn();
    int lat, nd; logic [N_B-1:0] kill, exp; bit bs, ko;
    do_reset(3);
    clear_field();
    m_ex[0] = 100; m_ey[0] = 200; m_een[0] = 1;
    m_bx[0] = 120; m_by[0] = 210; m_ben[0] = 1;
    apply_inputs();
    for (int f = 0; f < 3; f++) begin
      model_frame(exp);
      run_scan(lat, kill, nd, bs, ko);
      n_checks++;
      if (kill !== exp) begin n_fail++; $display("FAIL kill_frame%0d: got %b want %b", f, kill, exp); end
    end
    n_checks++;
    if (dut.health[0] !== 3'd0 || enemy_boom[0] !== 1'b1 || enemy_alive[0] !== 1'b0) begin
      n_fail++; $display("FAIL kill_boom: health %0d boom %b alive %b want 0/1/0", dut.health[0], enemy_boom[0], enemy_alive[0]);
    end
    m_ben[0] = 0;
    apply_inputs();
    for (int k = 1; k <= BOOM; k++) begin
      model_frame(exp);
      run_scan(lat, kill, nd, bs, ko);
      n_checks++;
      if (enemy_boom[0] !== (k < BOOM)) begin n_fail++; $display("FAIL boom_hold tick%0d: got %b want %b", k, enemy_boom[0], (k < BOOM)); end
    end
    n_checks++;
    if (dut.health[0] !== 3'd3 || enemy_alive[0] !== 1'b1) begin n_fail++; $display("FAIL respawn_health: got %0d want 3", dut.health[0]); end
  endtask

  task automatic test_no_wrap();
    int lat, nd; logic [N_B-1:0] kill; bit bs, ko;
    do_reset(3);
    clear_field();
    m_ex[0] = 5; m_ey[0] = 10; m_een[0] = 1;
    m_bx[0] = 1000; m_by[0] = 1000; m_ben[0] = 1;
    apply_inputs();
    run_scan(lat, kill, nd, bs, ko);
    n_checks++;
    if (kill !== 4'b0000) begin n_fail++; $display("FAIL nowrap_far: got %b want 0000", kill); end
    m_bx[0] = 0; m_by[0] = 0;
    apply_inputs();
    run_scan(lat, kill, nd, bs, ko);
    n_checks++;
    if (kill !== 4'b0001) begin n_fail++; $display("FAIL nowrap_origin: got %b want 0001", kill); end
    m_ex[0] = 1000; m_ey[0] = 1000; m_bx[0] = 1023; m_by[0] = 1023;
    apply_inputs();
    run_scan(lat, kill, nd, bs, ko);
    n_checks++;
    if (kill !== 4'b0001 || dut.health[0] !== 3'd1) begin n_fail++; $display("FAIL top_corner: kill %b health %0d want 0001/1", kill, dut.health[0]); end
    // Window edges: x low inclusive, x high exclusive, y low exclusive, y high exclusive.
    do_reset(3);
    m_ex[0] = 100; m_ey[0] = 200;
    m_bx[0] = 90;  m_by[0] = 210; m_ben[0] = 1;
    m_bx[1] = 150; m_by[1] = 210; m_ben[1] = 1;
    m_bx[2] = 120; m_by[2] = 160; m_ben[2] = 1;
    m_bx[3] = 120; m_by[3] = 249; m_ben[3] = 1;
    apply_inputs();
    run_scan(lat, kill, nd, bs, ko);
    n_checks++;
    if (kill !== 4'b1001 || dut.health[0] !== 3'd1) begin n_fail++; $display("FAIL window_edges: kill %b health %0d want 1001/1", kill, dut.health[0]); end
  endtask

  task automatic test_priority();
    int lat, nd; logic [N_B-1:0] kill; bit bs, ko;
    do_reset(3);
    clear_field();
    m_ex[0] = 100; m_ey[0] = 200; m_een[0] = 1;
    m_ex[1] = 100; m_ey[1] = 200; m_een[1] = 1;
    m_bx[0] = 120; m_by[0] = 210; m_ben[0] = 1;
    apply_inputs();
    run_scan(lat, kill, nd, bs, ko);
    n_checks++;
    if (kill !== 4'b0001) begin n_fail++; $display("FAIL prio_kill: got %b want 0001", kill); end
    n_checks++;
    if (dut.health[0] !== 3'd2 || dut.health[1] !== 3'd3) begin n_fail++; $display("FAIL prio_health: got %0d/%0d want 2/3", dut.health[0], dut.health[1]); end
  endtask

  task automatic test_overrun_snapshot();
    int nd; logic [N_B-1:0] kill; bit ovr_early;
    do_reset(3);
    clear_field();
    m_ex[0] = 100; m_ey[0] = 200; m_een[0] = 1;
    m_bx[0] = 120; m_by[0] = 210; m_ben[0] = 1;
    apply_inputs();
    @(negedge clk);
    frame_tick = 1'b1;
    nd = 0; kill = '0; ovr_early = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) frame_tick = 1'b0;
      if (i == 2) begin
        // Move everything away mid-scan; the snapshot must keep the hit.
        b_x[9:0] = 10'd900; bullet_en = '0; enemy_en = '0;
      end
      if (i == 4) ovr_early = overrun;
      if (i == 5) frame_tick = 1'b1;
      if (i == 6) frame_tick = 1'b0;
      if (scan_done) begin nd++; kill = bullet_kill; end
    end
    n_checks++;
    if (ovr_early !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b want 0", ovr_early); end
    n_checks++;
    if (nd !== 1) begin n_fail++; $display("FAIL overrun_done_count: got %0d want 1", nd); end
    n_checks++;
    if (kill !== 4'b0001 || dut.health[0] !== 3'd2) begin n_fail++; $display("FAIL snapshot_hit: kill %b health %0d want 0001/2", kill, dut.health[0]); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    do_reset(3);
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_reset: got %b want 0", overrun); end
  endtask

  task automatic test_abort_reset();
    int nd; bit kill_seen; logic busy_async;
    do_reset(3);
    clear_field();
    m_ex[0] = 100; m_ey[0] = 200; m_een[0] = 1;
    m_bx[0] = 120; m_by[0] = 210; m_ben[0] = 1;
    apply_inputs();
    @(negedge clk);
    frame_tick = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) frame_tick = 1'b0;
    end
    rst = 1'b1;
    #1 busy_async = busy;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy_async !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b/%b want 0", busy_async, busy); end
    nd = 0; kill_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (scan_done) nd++;
      if (bullet_kill != '0) kill_seen = 1'b1;
    end
    n_checks++;
    if (nd !== 0 || kill_seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_report: done %0d kill %b want 0/0", nd, kill_seen); end
    for (int i = 0; i < N_EN; i++) begin
      n_checks++;
      if (dut.health[i] !== 3'd3) begin n_fail++; $display("FAIL abort_health[%0d]: got %0d want 3", i, dut.health[i]); end
    end
  endtask

  task automatic test_random();
    int lat, nd, t, off; logic [N_B-1:0] kill, exp; bit bs, ko;
    do_reset(int'($urandom_range(0, 4)));
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < N_EN; i++) begin
        m_een[i] = ($urandom_range(0, 3) != 0);
        m_ex[i]  = int'($urandom_range(0, 1023));
        m_ey[i]  = int'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 2) == 0) begin m_ex[1] = m_ex[0]; m_ey[1] = m_ey[0]; end
      for (int j = 0; j < N_B; j++) begin
        m_ben[j] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) != 0) begin
          t = int'($urandom_range(0, N_EN - 1));
          off = int'($urandom_range(0, 80)) - 20;
          m_bx[j] = m_ex[t] + off;
          off = int'($urandom_range(0, 110)) - 50;
          m_by[j] = m_ey[t] + off;
          if (m_bx[j] < 0) m_bx[j] = 0;
          if (m_bx[j] > 1023) m_bx[j] = 1023;
          if (m_by[j] < 0) m_by[j] = 0;
          if (m_by[j] > 1023) m_by[j] = 1023;
        end else begin
          m_bx[j] = int'($urandom_range(0, 1023));
          m_by[j] = int'($urandom_range(0, 1023));
        end
      end
      apply_inputs();
      model_frame(exp);
      run_scan(lat, kill, nd, bs, ko);
      n_checks++;
      if (lat !== 17 || nd !== 1) begin n_fail++; $display("FAIL rand%0d_timing: lat %0d done %0d want 17/1", f, lat, nd); end
      n_checks++;
      if (kill !== exp || ko !== 1'b0) begin n_fail++; $display("FAIL rand%0d_kill: got %b stray %b want %b", f, kill, ko, exp); end
      for (int i = 0; i < N_EN; i++) begin
        n_checks++;
        if (int'(dut.health[i]) !== m_health[i] || enemy_boom[i] !== (m_cnt[i] != 0) ||
            enemy_alive[i] !== (m_health[i] != 0)) begin
          n_fail++;
          $display("FAIL rand%0d_enemy%0d: health %0d boom %b alive %b want %0d/%b/%b", f, i,
                   dut.health[i], enemy_boom[i], enemy_alive[i], m_health[i], (m_cnt[i] != 0), (m_health[i] != 0));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    health_init = 3'd3;
    test_reset();
    test_single_hit();
    test_kill_respawn();
    test_no_wrap();
    test_priority();
    test_overrun_snapshot();
    test_abort_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
